// File: rtl/poseidon_top_level_if.sv
// ---------------------------------------------------------------------------
// poseidon_top_level_if
//
// Stream bundle for the Poseidon sponge core: one valid/ready input stream
// carrying field elements framed by `last`, and one valid/ready output stream
// carrying the digest.
//
// Signals:
//   io_input_valid     source -> core   input element valid
//   io_input_ready     core   -> source core accepts an element this cycle
//   io_input_last      source -> core   element closes the message
//   io_input_payload   source -> core   255-bit element, unsigned
//   io_output_valid    core   -> sink   digest valid
//   io_output_ready    sink   -> core   sink accepts the digest
//   io_output_last     core   -> sink   mirrors io_output_valid
//   io_output_payload  core   -> sink   255-bit digest
//
// Modports:
//   master : the stream source/sink side (BFM or wrapper)
//   slave  : the hashing core
// ---------------------------------------------------------------------------
interface poseidon_top_level_if;
    logic         io_input_valid;
    logic         io_input_ready;
    logic         io_input_last;
    logic [254:0] io_input_payload;
    logic         io_output_valid;
    logic         io_output_ready;
    logic         io_output_last;
    logic [254:0] io_output_payload;

    modport master (
        output io_input_valid,
        output io_input_last,
        output io_input_payload,
        output io_output_ready,
        input  io_input_ready,
        input  io_output_valid,
        input  io_output_last,
        input  io_output_payload
    );

    modport slave (
        input  io_input_valid,
        input  io_input_last,
        input  io_input_payload,
        input  io_output_ready,
        output io_input_ready,
        output io_output_valid,
        output io_output_last,
        output io_output_payload
    );
endinterface

// File: rtl/poseidon_top_level.sv
// ---------------------------------------------------------------------------
// poseidon_top_level
//
// Streaming Poseidon sponge hash over the BN254 scalar field (t = 3,
// 8 full rounds, 57 partial rounds, x^5 S-box). Elements arriving on the
// input stream are reduced mod P and absorbed alternately into S[1] and S[2];
// the permutation runs after each pair or after an element flagged `last`.
// After the final permutation of a message, S[1] is offered as the digest.
//
// Ports:
//   clk     : single clock, rising edge
//   resetn  : synchronous reset, asserted HIGH despite the name
//   bus     : poseidon_top_level_if.slave (input and output streams)
//
// Datapath: one shared modular multiplier, interleaved double-and-add
// (MSB first, reduced after every step). Each clock retires BPC bits of the
// multiplier operand, so every multiply takes a fixed MUL_CYCLES cycles.
// Additions and the MDS mix use adders plus one conditional subtraction.
//
// Permutation latency (accepting edge to io_output_valid / ready return):
//   ROUNDS * 2 (add-constants + mix) + 243 * (1 + MUL_CYCLES) cycles.
// ---------------------------------------------------------------------------
module poseidon_top_level (
    input  logic                 clk,
    input  logic                 resetn,
    poseidon_top_level_if.slave  bus
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int T      = 3;
    localparam int RF     = 8;
    localparam int RP     = 57;
    localparam int ROUNDS = RF + RP;
    localparam int HALF_F = RF / 2;

    localparam logic [255:0] P  =
        256'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;
    localparam logic [255:0] P2 = P << 1;

    // Multiplier operand is padded to 256 bits and consumed BPC bits a clock.
    localparam int         BPC        = 16;
    localparam int         MUL_CYCLES = 256 / BPC;
    localparam logic [3:0] LAST_MUL   = 4'(MUL_CYCLES - 1);

    typedef logic [254:0] fe_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ABSORB,
        ST_ARC,
        ST_LOAD,
        ST_MUL,
        ST_MIX,
        ST_OUTPUT
    } state_t;

    // ------------------------------------------------------------------
    // Field helpers
    // ------------------------------------------------------------------
    // a + b mod P for a, b < P: the sum is below 2P, one subtraction suffices.
    function automatic fe_t add_mod(input fe_t a, input fe_t b);
        logic [255:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= P) sum = sum - P;
        return sum[254:0];
    endfunction

    // Any 255-bit value is below 3P, so at most two subtractions of P bring
    // it into range; doing it as "2P or P" keeps it to a single stage.
    function automatic fe_t reduce_in(input fe_t x);
        logic [255:0] v;
        v = {1'b0, x};
        if (v >= P2)     v = v - P2;
        else if (v >= P) v = v - P;
        return v[254:0];
    endfunction

    // BPC steps of MSB-first double-and-add: acc = 2*acc (+ a) mod P.
    function automatic fe_t mul_steps(input fe_t acc_in, input fe_t a,
                                      input logic [BPC-1:0] bits);
        fe_t          acc_v;
        logic [255:0] dbl;
        acc_v = acc_in;
        for (int i = BPC - 1; i >= 0; i--) begin
            dbl = {acc_v, 1'b0};
            if (dbl >= P) dbl = dbl - P;
            acc_v = dbl[254:0];
            if (bits[i]) acc_v = add_mod(acc_v, a);
        end
        return acc_v;
    endfunction

    // Round constant RC(r, j) = 3r + j + 1.
    function automatic fe_t rc(input logic [6:0] r, input logic [1:0] j);
        logic [8:0] v;
        v = {2'b00, r} * 9'd3 + {7'b0, j} + 9'd1;
        return {246'd0, v};
    endfunction

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t       state;
    fe_t          s [T];          // sponge state: s[0] capacity, s[1..2] rate
    logic         phase;          // 0: next element goes to s[1], 1: to s[2]
    logic         msg_done;       // the running permutation closes the message
    logic [6:0]   round;
    logic [1:0]   elem;           // S-box element being processed
    logic [1:0]   step;           // 0: x*x, 1: x^2*x^2, 2: x^4*x
    fe_t          tmp;            // x^2, then x^4
    fe_t          mul_a;
    logic [255:0] mul_b;          // shifted left BPC bits per multiply cycle
    fe_t          acc;
    logic [3:0]   mul_cnt;
    logic         in_ready;
    logic         out_valid;
    fe_t          out_payload;

    // ------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------
    fe_t  in_red;
    fe_t  x_sel;
    fe_t  mul_next;
    fe_t  mix_sum;
    fe_t  mix_next [T];
    logic full_round;

    assign in_red     = reduce_in(bus.io_input_payload);
    assign x_sel      = s[elem];
    assign mul_next   = mul_steps(acc, mul_a, mul_b[255 -: BPC]);
    assign full_round = (round < 7'(HALF_F)) || (round >= 7'(ROUNDS - HALF_F));

    // M = [[2,1,1],[1,2,1],[1,1,2]] means row j is (s0 + s1 + s2) + s[j].
    // NOTE: every variable here is written on every pass, which is what keeps
    // always_comb from turning into a latch.
    always_comb begin
        mix_sum = add_mod(add_mod(s[0], s[1]), s[2]);
        for (int j = 0; j < T; j++) begin
            mix_next[j] = add_mod(mix_sum, s[j]);
        end
    end

    // ------------------------------------------------------------------
    // Control FSM and datapath registers
    // ------------------------------------------------------------------
    // NOTE: resetn is active-high here; "n" in the name does not mean low.
    // NOTE: the sponge state array is reset on purpose -- a cleared state is
    // part of the hash definition, not just an initial value.
    // NOTE: every register below uses <= so all of them update together from
    // the values seen at the edge, regardless of statement order.
    always_ff @(posedge clk) begin
        if (resetn) begin
            state       <= ST_IDLE;
            for (int j = 0; j < T; j++) s[j] <= '0;
            phase       <= 1'b0;
            msg_done    <= 1'b0;
            round       <= '0;
            elem        <= '0;
            step        <= '0;
            tmp         <= '0;
            mul_a       <= '0;
            mul_b       <= '0;
            acc         <= '0;
            mul_cnt     <= '0;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            out_payload <= '0;
        end else begin
            case (state)
                // One quiet cycle after reset before the input opens.
                ST_IDLE: begin
                    in_ready <= 1'b1;
                    state    <= ST_ABSORB;
                end

                ST_ABSORB: begin
                    if (bus.io_input_valid && in_ready) begin
                        if (!phase) s[1] <= add_mod(s[1], in_red);
                        else        s[2] <= add_mod(s[2], in_red);
                        if (phase || bus.io_input_last) begin
                            phase    <= 1'b0;
                            msg_done <= bus.io_input_last;
                            in_ready <= 1'b0;
                            round    <= '0;
                            state    <= ST_ARC;
                        end else begin
                            phase <= 1'b1;
                        end
                    end
                end

                ST_ARC: begin
                    for (int j = 0; j < T; j++) begin
                        s[j] <= add_mod(s[j], rc(round, 2'(j)));
                    end
                    elem  <= '0;
                    step  <= '0;
                    state <= ST_LOAD;
                end

                // Pick operands for the next S-box multiply.
                ST_LOAD: begin
                    mul_a   <= (step == 2'd0) ? x_sel : tmp;
                    mul_b   <= {1'b0, (step == 2'd1) ? tmp : x_sel};
                    acc     <= '0;
                    mul_cnt <= '0;
                    state   <= ST_MUL;
                end

                ST_MUL: begin
                    if (mul_cnt == LAST_MUL) begin
                        if (step != 2'd2) begin
                            tmp   <= mul_next;
                            step  <= step + 2'd1;
                            state <= ST_LOAD;
                        end else begin
                            s[elem] <= mul_next;
                            step    <= '0;
                            // Partial rounds only raise s[0] to the fifth power.
                            if (full_round && elem != 2'd2) begin
                                elem  <= elem + 2'd1;
                                state <= ST_LOAD;
                            end else begin
                                elem  <= '0;
                                state <= ST_MIX;
                            end
                        end
                    end else begin
                        acc     <= mul_next;
                        mul_b   <= mul_b << BPC;
                        mul_cnt <= mul_cnt + 4'd1;
                    end
                end

                ST_MIX: begin
                    for (int j = 0; j < T; j++) s[j] <= mix_next[j];
                    if (round == 7'(ROUNDS - 1)) begin
                        round <= '0;
                        if (msg_done) begin
                            out_valid   <= 1'b1;
                            out_payload <= mix_next[1];
                            state       <= ST_OUTPUT;
                        end else begin
                            in_ready <= 1'b1;
                            state    <= ST_ABSORB;
                        end
                    end else begin
                        round <= round + 7'd1;
                        state <= ST_ARC;
                    end
                end

                // Digest held until taken; taking it starts a fresh message.
                ST_OUTPUT: begin
                    if (bus.io_output_ready) begin
                        for (int j = 0; j < T; j++) s[j] <= '0;
                        phase       <= 1'b0;
                        msg_done    <= 1'b0;
                        out_valid   <= 1'b0;
                        out_payload <= '0;
                        in_ready    <= 1'b1;
                        state       <= ST_ABSORB;
                    end
                end

                default: begin
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.io_input_ready    = in_ready;
    assign bus.io_output_valid   = out_valid;
    assign bus.io_output_last    = out_valid;
    assign bus.io_output_payload = out_payload;

endmodule

// File: tb/tb_poseidon_top_level.sv
// ---------------------------------------------------------------------------
// tb_poseidon_top_level
//
// Self-checking bench for poseidon_top_level. Expected digests come from a
// reference Poseidon sponge written with plain wide % arithmetic. A vector
// table covers single-element, reduction and two-element messages; hand-
// written sequences cover reset release, output backpressure and reset
// asserted in the middle of a permutation.
// ---------------------------------------------------------------------------
module tb_poseidon_top_level;

    typedef logic [254:0]      fe_t;
    typedef logic [2:0][254:0] st_t;

    localparam logic [255:0] P =
        256'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;
    localparam int LAT_MAX = 70000;
    localparam int NV      = 8;

    logic clk = 1'b0;
    logic resetn;

    always #5 clk = ~clk;

    poseidon_top_level_if bus ();

    poseidon_top_level dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic fe_t g_red(input fe_t x);
        logic [255:0] v;
        v = {1'b0, x} % P;
        return v[254:0];
    endfunction

    function automatic fe_t g_add(input fe_t a, input fe_t b);
        logic [255:0] v;
        v = ({1'b0, a} + {1'b0, b}) % P;
        return v[254:0];
    endfunction

    function automatic fe_t g_mul(input fe_t a, input fe_t b);
        logic [511:0] v;
        v = ({257'd0, a} * {257'd0, b}) % {256'd0, P};
        return v[254:0];
    endfunction

    function automatic fe_t g_pow5(input fe_t x);
        fe_t x2, x4;
        x2 = g_mul(x, x);
        x4 = g_mul(x2, x2);
        return g_mul(x4, x);
    endfunction

    function automatic st_t g_perm(input st_t s_in);
        st_t st;
        fe_t sum;
        st = s_in;
        for (int r = 0; r < 65; r++) begin
            for (int j = 0; j < 3; j++) st[j] = g_add(st[j], fe_t'(3 * r + j + 1));
            for (int j = 0; j < 3; j++) begin
                if (r < 4 || r >= 61 || j == 0) st[j] = g_pow5(st[j]);
            end
            sum = g_add(g_add(st[0], st[1]), st[2]);
            for (int j = 0; j < 3; j++) st[j] = g_add(sum, st[j]);
        end
        return st;
    endfunction

    function automatic fe_t g_sponge(input int n, input fe_t x0, input fe_t x1);
        st_t st;
        st    = '0;
        st[1] = g_add(st[1], g_red(x0));
        if (n == 2) st[2] = g_add(st[2], g_red(x1));
        st = g_perm(st);
        return st[1];
    endfunction

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    task automatic check_val(input string name, input fe_t act, input fe_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic abort_run(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out waiting for the DUT", name);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    // ------------------------------------------------------------------
    // Stream drivers (entered and left on a falling edge)
    // ------------------------------------------------------------------
    task automatic send_elem(input fe_t x, input logic last);
        int w;
        bus.io_input_valid   = 1'b1;
        bus.io_input_payload = x;
        bus.io_input_last    = last;
        w = 0;
        while (bus.io_input_ready !== 1'b1) begin
            @(negedge clk);
            w++;
            if (w > LAT_MAX) abort_run("input_ready_wait");
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_msg(input int n, input fe_t x0, input fe_t x1);
        if (n == 2) begin
            send_elem(x0, 1'b0);
            check_bit("ready_between_pair", bus.io_input_ready, 1'b1);
            send_elem(x1, 1'b1);
        end else begin
            send_elem(x0, 1'b1);
        end
        bus.io_input_valid   = 1'b0;
        bus.io_input_last    = 1'b0;
        bus.io_input_payload = '0;
    endtask

    // Counts falling edges from the accepting edge until io_output_valid,
    // and how many of them saw io_input_ready low.
    task automatic wait_digest(output fe_t d, output int lat, output int rlow);
        lat  = 0;
        rlow = 0;
        while (bus.io_output_valid !== 1'b1) begin
            if (bus.io_input_ready === 1'b0) rlow++;
            @(negedge clk);
            lat++;
            if (lat > LAT_MAX) abort_run("output_valid_wait");
        end
        d = bus.io_output_payload;
    endtask

    task automatic take_digest(input string name);
        bus.io_output_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_bit({name, "_valid_cleared"}, bus.io_output_valid, 1'b0);
        check_bit({name, "_ready_back"}, bus.io_input_ready, 1'b1);
    endtask

    // last=1 without valid must not frame anything.
    task automatic idle_noise();
        bus.io_input_valid = 1'b0;
        bus.io_input_last  = 1'b1;
        repeat (2) @(negedge clk);
        bus.io_input_last  = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Vector table
    // ------------------------------------------------------------------
    typedef struct {
        int  n;
        fe_t x0;
        fe_t x1;
        fe_t exp;
    } vec_t;

    vec_t vecs [NV];
    fe_t  dig  [NV];

    initial begin
        #(5_000_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        fe_t all1, x3, d, p0;
        int  lat, rlow, lat_ref, changes, rdy_bad, extra;

        all1 = '1;
        x3   = all1 - fe_t'(P << 1);

        vecs[0] = '{1, fe_t'(0),    fe_t'(0), g_sponge(1, fe_t'(0), fe_t'(0))};
        vecs[1] = '{1, fe_t'(P),    fe_t'(0), g_sponge(1, fe_t'(0), fe_t'(0))};
        vecs[2] = '{1, all1,        fe_t'(0), g_sponge(1, x3, fe_t'(0))};
        vecs[3] = '{1, x3,          fe_t'(0), g_sponge(1, x3, fe_t'(0))};
        vecs[4] = '{2, fe_t'(1),    fe_t'(2), g_sponge(2, fe_t'(1), fe_t'(2))};
        vecs[5] = '{1, fe_t'(1),    fe_t'(0), g_sponge(1, fe_t'(1), fe_t'(0))};
        vecs[6] = '{1, fe_t'(2),    fe_t'(0), g_sponge(1, fe_t'(2), fe_t'(0))};
        vecs[7] = '{1, fe_t'(5),    fe_t'(0), g_sponge(1, fe_t'(5), fe_t'(0))};

        // ---------------- reset release ----------------
        resetn               = 1'b1;
        bus.io_input_valid   = 1'b0;
        bus.io_input_last    = 1'b0;
        bus.io_input_payload = '0;
        bus.io_output_ready  = 1'b1;
        repeat (3) @(negedge clk);
        check_bit("rst_input_ready",  bus.io_input_ready,  1'b0);
        check_bit("rst_output_valid", bus.io_output_valid, 1'b0);
        check_bit("rst_output_last",  bus.io_output_last,  1'b0);
        check_val("rst_output_payload", bus.io_output_payload, fe_t'(0));
        resetn = 1'b0;
        #1;
        check_bit("release_cycle1_ready", bus.io_input_ready,  1'b0);
        check_bit("release_cycle1_valid", bus.io_output_valid, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check_bit("release_cycle2_ready", bus.io_input_ready, 1'b1);

        // ---------------- table-driven messages ----------------
        lat_ref = 0;
        for (int i = 0; i < NV; i++) begin
            idle_noise();
            send_msg(vecs[i].n, vecs[i].x0, vecs[i].x1);
            wait_digest(d, lat, rlow);
            dig[i] = d;
            check_val($sformatf("vec%0d_digest", i), d, vecs[i].exp);
            check_bit($sformatf("vec%0d_last", i), bus.io_output_last, 1'b1);
            check_bit($sformatf("vec%0d_bit254", i), d[254], 1'b0);
            check_int($sformatf("vec%0d_ready_low_cycles", i), rlow, lat);
            if (i == 0) begin
                lat_ref = lat;
                check_bit("latency_within_bound", lat <= LAT_MAX, 1'b1);
            end else begin
                check_int($sformatf("vec%0d_latency", i), lat, lat_ref);
            end
            take_digest($sformatf("vec%0d", i));
        end

        check_val("reduce_P_same_as_0", dig[1], dig[0]);
        check_val("reduce_max_same_as_max_minus_2P", dig[2], dig[3]);
        check_bit("pair_differs_from_1", dig[4] != dig[5], 1'b1);
        check_bit("pair_differs_from_2", dig[4] != dig[6], 1'b1);

        // ---------------- output backpressure ----------------
        bus.io_output_ready = 1'b0;
        send_msg(1, fe_t'(3), fe_t'(0));
        wait_digest(p0, lat, rlow);
        check_val("bp_digest", p0, g_sponge(1, fe_t'(3), fe_t'(0)));
        changes = 0;
        rdy_bad = 0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.io_output_valid !== 1'b1 || bus.io_output_last !== 1'b1 ||
                bus.io_output_payload !== p0) changes++;
            if (bus.io_input_ready !== 1'b0) rdy_bad++;
        end
        check_int("bp_output_changes", changes, 0);
        check_int("bp_input_ready_high", rdy_bad, 0);
        take_digest("bp");
        extra = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.io_output_valid !== 1'b0) extra++;
        end
        check_int("bp_second_digest", extra, 0);

        // ---------------- reset in the middle of a permutation ----------------
        send_msg(1, fe_t'(7), fe_t'(0));
        repeat (1000) @(negedge clk);
        check_bit("midperm_busy", bus.io_input_ready, 1'b0);
        resetn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b0;
        check_bit("abort_no_digest", bus.io_output_valid, 1'b0);
        check_bit("abort_ready_low", bus.io_input_ready,  1'b0);
        @(posedge clk);
        @(negedge clk);
        check_bit("abort_ready_back", bus.io_input_ready, 1'b1);
        send_msg(1, fe_t'(5), fe_t'(0));
        wait_digest(d, lat, rlow);
        check_val("abort_then_5_golden", d, vecs[7].exp);
        check_val("abort_then_5_vs_clean", d, dig[7]);
        check_int("abort_then_5_latency", lat, lat_ref);
        take_digest("abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
